// File: rtl/pulse_report_pkg.sv
// pulse_report_pkg: packet constants, record field positions, FSM encoding and tolerance check for pulse_result_reporter
package pulse_report_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam int PKT_LEN = 10;
  localparam int FLAG_TIMEOUT = 0;
  localparam int FLAG_FAULT = 1;
  localparam int TIMEOUT_BIT = 56;
  localparam int DELAY_MSB = 55;
  localparam int DELAY_LSB = 24;
  localparam int VAR_MSB = 23;
  localparam int VAR_LSB = 0;
  typedef enum logic [1:0] {IDLE, POP, CAPTURE, SEND} state_t;
  // Magnitude of 0x800000 negates to itself, which as unsigned exceeds any 24-bit tolerance below 2^23.
  function automatic logic is_fault(input logic [23:0] v, input logic [23:0] tol);
    logic [23:0] mag;
    mag = v[23] ? 24'(-v) : v;
    return mag > tol;
  endfunction
endpackage

// File: rtl/pulse_stat_counter.sv
// pulse_stat_counter: 16-bit saturating counter; clk, rst (async high), inc, clr (priority) -> count
module pulse_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/pulse_result_reporter.sv
// pulse_result_reporter: pops 57-bit records (fifo_*), sends 10-byte XOR-checked packets (tx_*), keeps rec/timeout/fault counters
module pulse_result_reporter
  import pulse_report_pkg::*;
#(
  parameter logic [23:0] TOL = 24'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [56:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        clear_stats,
  output logic [15:0] rec_count,
  output logic [15:0] timeout_count,
  output logic [15:0] fault_count
);
  state_t state, nxt;
  logic [3:0] idx;
  logic [7:0] flags, fl, pkt_byte, csum;
  logic [31:0] delay;
  logic [23:0] var_r;
  logic hs, cap, rec_to, rec_fault;
  assign hs = tx_valid && tx_ready;
  assign cap = state == CAPTURE;
  assign rec_to = fifo_dout[TIMEOUT_BIT];
  assign rec_fault = !rec_to && is_fault(fifo_dout[VAR_MSB:VAR_LSB], TOL);
  assign tx_valid = state == SEND;
  assign tx_data = tx_valid ? pkt_byte : 8'h00;
  assign csum = flags ^ delay[31:24] ^ delay[23:16] ^ delay[15:8] ^ delay[7:0]
              ^ var_r[23:16] ^ var_r[15:8] ^ var_r[7:0];
  always_comb begin
    fl = '0;
    fl[FLAG_TIMEOUT] = rec_to;
    fl[FLAG_FAULT] = rec_fault;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (en && !fifo_empty) ? POP : IDLE;
      POP:     nxt = CAPTURE;
      CAPTURE: nxt = SEND;
      SEND:    nxt = (hs && idx == 4'(PKT_LEN - 1)) ? IDLE : SEND;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    pkt_byte = 8'h00;
    case (idx)
      4'd0: pkt_byte = SYNC_BYTE;
      4'd1: pkt_byte = flags;
      4'd2: pkt_byte = delay[31:24];
      4'd3: pkt_byte = delay[23:16];
      4'd4: pkt_byte = delay[15:8];
      4'd5: pkt_byte = delay[7:0];
      4'd6: pkt_byte = var_r[23:16];
      4'd7: pkt_byte = var_r[15:8];
      4'd8: pkt_byte = var_r[7:0];
      4'd9: pkt_byte = csum;
      default: pkt_byte = 8'h00;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      fifo_rd_en <= 1'b0;
      flags <= '0;
      delay <= '0;
      var_r <= '0;
    end else begin
      state <= nxt;
      fifo_rd_en <= nxt == POP;
      idx <= (state == SEND) ? idx + 4'(hs) : 4'd0;
      if (cap) begin
        flags <= fl;
        delay <= rec_to ? 32'h0 : fifo_dout[DELAY_MSB:DELAY_LSB];
        var_r <= rec_to ? 24'h0 : fifo_dout[VAR_MSB:VAR_LSB];
      end
    end
  pulse_stat_counter u_rec (.clk(clk), .rst(rst), .inc(cap), .clr(clear_stats), .count(rec_count));
  pulse_stat_counter u_to (.clk(clk), .rst(rst), .inc(cap && rec_to), .clr(clear_stats), .count(timeout_count));
  pulse_stat_counter u_flt (.clk(clk), .rst(rst), .inc(cap && rec_fault), .clr(clear_stats), .count(fault_count));
endmodule

// File: tb/tb_pulse_result_reporter.sv
// tb_pulse_result_reporter: directed-vector self-checking bench for pulse_result_reporter
module tb_pulse_result_reporter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, fifo_empty = 1'b1, tx_ready = 1'b0, clear_stats = 1'b0;
  logic [56:0] fifo_dout = '0;
  logic fifo_rd_en, tx_valid;
  logic [7:0] tx_data;
  logic [15:0] rec_count, timeout_count, fault_count;
  logic sc_inc = 1'b0, sc_clr = 1'b0;
  logic [15:0] sc_count;
  int n_cmp = 0, n_bad = 0, cyc = 0, stall_bad = 0;
  bit rnd = 0, stall_done = 1;
  logic [56:0] q[$];
  logic [7:0] got[$];
  int pulses[$];
  logic [7:0] eb[10];
  localparam logic [56:0] REC_TO = 57'h180000000000000;
  localparam logic [56:0] REC_OK = {1'b0, 32'h00001234, 24'h000003};
  localparam logic [56:0] REC_FLT = {1'b0, 32'h00000010, 24'hFFFFE0};
  pulse_result_reporter dut (
    .clk(clk), .rst(rst), .en(en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .clear_stats(clear_stats), .rec_count(rec_count), .timeout_count(timeout_count),
    .fault_count(fault_count)
  );
  pulse_stat_counter u_sc (.clk(clk), .rst(rst), .inc(sc_inc), .clr(sc_clr), .count(sc_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      pulses.push_back(cyc);
      if (q.size() > 0) fifo_dout = q.pop_front();
      fifo_empty = q.size() == 0;
    end
    if (tx_valid && tx_ready) got.push_back(tx_data);
  end
  always @(posedge clk) begin
    #1;
    if (rnd) begin
      if (!stall_done && got.size() == 4 && tx_valid) begin
        tx_ready = 1'b0;
        repeat (50) begin
          @(negedge clk);
          if (tx_data !== 8'h00 || !tx_valid || fifo_rd_en) stall_bad++;
          @(posedge clk);
          #1;
        end
        stall_done = 1;
      end
      tx_ready = 1'($urandom_range(0, 1));
    end
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [56:0] r);
    q.push_back(r);
    fifo_empty = 1'b0;
  endtask
  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (got.size() < n) chk("byte_wait", 64'(got.size()), 64'(n));
  endtask
  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pulses.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (pulses.size() < n) chk("pulse_wait", 64'(pulses.size()), 64'(n));
  endtask
  task automatic chk_pkt(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (got.size() > 0) chk($sformatf("%s_b%0d", tag, i), 64'(got.pop_front()), 64'(eb[i]));
      else chk($sformatf("%s_b%0d_missing", tag, i), 64'(0), 64'(1));
    end
  endtask
  task automatic chk_cnt(input string tag, input int r, input int t, input int f);
    chk({tag, "_rec"}, 64'(rec_count), 64'(r));
    chk({tag, "_to"}, 64'(timeout_count), 64'(t));
    chk({tag, "_flt"}, 64'(fault_count), 64'(f));
  endtask
  task automatic set_to;
    eb = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  endtask
  task automatic set_ok;
    eb = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h03, 8'h25};
  endtask
  task automatic set_flt;
    eb = '{8'h5A, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hE0, 8'hF2};
  endtask
  initial begin
    step(3);
    chk("rst_valid", 64'(tx_valid), 0);
    chk("rst_rd_en", 64'(fifo_rd_en), 0);
    chk("rst_data", 64'(tx_data), 0);
    chk_cnt("rst", 0, 0, 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    en = 1'b1;
    push(REC_TO);
    wait_bytes(10, 100);
    set_to();
    chk_pkt("timeout");
    step(2);
    chk_cnt("timeout", 1, 1, 0);
    chk("timeout_pops", 64'(pulses.size()), 1);
    push(REC_OK);
    wait_bytes(10, 100);
    set_ok();
    chk_pkt("normal");
    step(2);
    chk_cnt("normal", 2, 1, 0);
    push(REC_FLT);
    wait_bytes(10, 100);
    set_flt();
    chk_pkt("fault");
    step(2);
    chk_cnt("fault", 3, 1, 1);
    pulses.delete();
    stall_done = 0;
    rnd = 1;
    push(REC_FLT);
    wait_bytes(10, 2000);
    set_flt();
    chk_pkt("stall");
    chk("stall_stable", 64'(stall_bad), 0);
    chk("stall_seen", 64'(stall_done), 1);
    rnd = 0;
    step(3);
    tx_ready = 1'b1;
    chk("stall_pops", 64'(pulses.size()), 1);
    chk_cnt("stall", 4, 1, 2);
    pulses.delete();
    push(REC_OK);
    wait_pulses(1, 50);
    @(posedge clk);
    #1;
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    @(negedge clk);
    chk_cnt("clr_cap", 0, 0, 0);
    chk("clr_first_byte", 64'(tx_data), 64'h5A);
    wait_bytes(10, 100);
    set_ok();
    chk_pkt("clr_pkt");
    pulses.delete();
    push(REC_TO);
    push(REC_OK);
    push(REC_FLT);
    wait_bytes(30, 200);
    chk("b2b_pops", 64'(pulses.size()), 3);
    if (pulses.size() == 3) begin
      chk("b2b_gap1", 64'(pulses[1] - pulses[0]), 13);
      chk("b2b_gap2", 64'(pulses[2] - pulses[1]), 13);
    end
    set_to();
    chk_pkt("b2b_0");
    set_ok();
    chk_pkt("b2b_1");
    set_flt();
    chk_pkt("b2b_2");
    step(2);
    chk_cnt("b2b", 3, 1, 1);
    pulses.delete();
    push(REC_OK);
    push(REC_FLT);
    push(REC_TO);
    wait_pulses(2, 100);
    step(4);
    chk("mid_valid", 64'(tx_valid), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(tx_valid), 0);
    chk("rstmid_rd_en", 64'(fifo_rd_en), 0);
    chk_cnt("rstmid", 0, 0, 0);
    en = 1'b0;
    step(2);
    rst = 1'b0;
    got.delete();
    pulses.delete();
    step(20);
    chk("idle_pops", 64'(pulses.size()), 0);
    chk("idle_bytes", 64'(got.size()), 0);
    chk("idle_valid", 64'(tx_valid), 0);
    en = 1'b1;
    wait_bytes(10, 100);
    set_to();
    chk_pkt("resume");
    step(2);
    chk("resume_pops", 64'(pulses.size()), 1);
    chk_cnt("resume", 1, 1, 0);
    sc_inc = 1'b1;
    step(65534);
    chk("sat_fffe", 64'(sc_count), 64'hFFFE);
    step(1);
    chk("sat_ffff", 64'(sc_count), 64'hFFFF);
    step(2);
    chk("sat_hold", 64'(sc_count), 64'hFFFF);
    sc_clr = 1'b1;
    step(1);
    chk("sat_clr", 64'(sc_count), 0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_result_reporter.md
# pulse_result_reporter

Downstream consumer of the pulse tester's 57-bit result FIFO. Pops one record at a time and decodes it as a timeout record or a measured delay/variance record. Checks the variance against a tolerance, frames the result as a 10-byte checksummed packet on a byte-stream valid/ready interface (UART TX side), and keeps saturating statistics counters.

## Interface
- TOL, 24'd16: variance tolerance; a record is a fault if |signed variance| > TOL.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  permits popping new records; a packet already started always completes.
- fifo_dout  in  57  record from the FIFO; valid the cycle after fifo_rd_en is sampled high (standard, non-FWFT FIFO).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  registered pop strobe; high for exactly one cycle per record.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
- clear_stats  in  1  synchronous clear of all counters.
- rec_count  out  16  records processed, saturating.
- timeout_count  out  16  timeout records, saturating.
- fault_count  out  16  out-of-tolerance records, saturating.

## Operation
- Record decode:
  - bit56 = 1: timeout record. Remaining bits are ignored; flags = 0x01; delay and variance bytes are sent as zero.
  - bit56 = 0: delay = [55:24] (unsigned 32-bit), variance = [23:0] (two's-complement 24-bit). flags = 0x02 if |variance| > TOL, else 0x00. Variance 0x800000 is always a fault.
- Packet, in order:
  - byte 0: sync 0x5A.
  - byte 1: flags.
  - bytes 2-5: delay, big-endian.
  - bytes 6-8: variance, big-endian.
  - byte 9: XOR of bytes 1-8.
- FSM states:
  - IDLE: if en && !fifo_empty, go to POP.
  - POP: fifo_rd_en = 1; go to CAPTURE.
  - CAPTURE: latch fifo_dout, decode, update counters; go to SEND with byte index 0.
  - SEND: hold tx_valid. On each handshake, increment the index. On the handshake of byte 9, go to IDLE.
- Counters:
  - rec_count increments on every record.
  - timeout_count increments on timeout records.
  - fault_count increments on fault records.
  - All three saturate at 0xFFFF.
  - clear_stats wins over a simultaneous increment.
- en is sampled only in IDLE. Deasserting en mid-packet does not truncate the packet.

## Timing
- Reset values: fifo_rd_en = 0, tx_valid = 0, tx_data = 0x00, all counters = 0, state = IDLE, byte index = 0.
- Reset mid-packet abandons the packet immediately. Any popped record is lost, and no partial resume occurs.
- Cycle N: IDLE samples en = 1 and fifo_empty = 0.
- N+1: fifo_rd_en = 1.
- N+2: fifo_dout is captured; counters show the new values from N+3.
- N+3: tx_valid = 1 with tx_data = 0x5A.
- With tx_ready held at 1, bytes occupy N+3 through N+12, IDLE is N+13, and the earliest next fifo_rd_en is N+14.
- Valid/ready rules:
  - tx_valid is never deasserted without a handshake.
  - tx_data is stable while tx_valid && !tx_ready.
  - The next byte appears the cycle after its handshake.
- fifo_rd_en is never asserted while fifo_empty = 1 at the IDLE decision. It is never asserted outside POP.
- tx_ready stalls of any length, including permanent ones, hold the FSM in SEND with no FIFO pops.

## Structure
- Package pulse_report_pkg holds:
  - SYNC_BYTE = 0x5A, PKT_LEN = 10.
  - FLAG_TIMEOUT = bit0, FLAG_FAULT = bit1.
  - Record field positions: TIMEOUT_BIT = 56, DELAY_MSB/LSB = 55/24, VAR_MSB/LSB = 23/0.
  - FSM state encoding.
- Sub-module pulse_stat_counter: 16-bit saturating counter with inc and clr inputs, clr priority, asynchronous reset. Instantiated three times.
- Packet bytes come from a 10-entry mux indexed by the byte counter over the latched record. There is no byte shift register.

## Test plan
- Timeout record 57'h180000000000000, tx_ready = 1 -> bytes 5A 01 00 00 00 00 00 00 00 01; rec_count = 1, timeout_count = 1, fault_count = 0.
- Normal record, delay 0x00001234, variance 0x000003, TOL = 16 -> bytes 5A 00 00 00 12 34 00 00 03 25; fault_count unchanged.
- Fault record, delay 0x00000010, variance 0xFFFFE0 (-32) -> bytes 5A 02 00 00 00 10 FF FF E0 F2; fault_count + 1.
- tx_ready toggled randomly, plus a 50-cycle stall on byte 4 -> tx_data stable during the stall, no extra fifo_rd_en, and the byte sequence matches the previous case.
- Three records queued back-to-back, tx_ready = 1 -> fifo_rd_en pulses spaced exactly 13 cycles apart; rst asserted mid-second packet -> tx_valid = 0 and counters = 0 immediately, and no further output until en is reasserted with the FIFO non-empty.
- rec_count preset near 0xFFFF via 65 535 timeout records, then 2 more -> stays at 0xFFFF; clear_stats asserted in the same cycle as CAPTURE -> counters read 0 at N+3.
